// File: rtl/complex_vector_packer_if.sv
// ---------------------------------------------------------------------------
// complex_vector_packer_if
//
// Purpose:
//   Bundles the input and output handshakes of complex_vector_packer into one
//   interface. The packer connects through the 'slave' modport. The producer
//   and consumer side (for example a testbench) connects through 'master'.
//
// Signals (widths derive from the parameters):
//   in_data   [IW-1:0]  input word, IW = element_width*no_of_row_by_vector_modules
//   in_valid            in_data is valid this cycle
//   in_ready            packer accepts in_data
//   flush               one-cycle pulse requesting emission of a partial word
//   out_data  [OW-1:0]  packed output word, OW = pack_factor*IW
//   out_valid           out_data is valid
//   out_ready           consumer takes out_data
//   out_count [CW-1:0]  number of valid input words held in out_data
// ---------------------------------------------------------------------------
interface complex_vector_packer_if #(
    parameter int element_width               = 64,
    parameter int no_of_row_by_vector_modules = 4,
    parameter int pack_factor                 = 2
);
    localparam int IW = element_width * no_of_row_by_vector_modules;
    localparam int OW = pack_factor * IW;
    localparam int CW = $clog2(pack_factor + 1);

    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;

    // The packer side: it consumes the input stream and produces the packed stream.
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, out_count
    );

    // The producer and consumer side of the packer.
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, out_count
    );
endinterface

// File: rtl/complex_vector_packer.sv
// ---------------------------------------------------------------------------
// complex_vector_packer
//
// Purpose:
//   N:1 gatherer. It packs pack_factor consecutive row-by-vector result words
//   into one wide output word. Both sides use a valid/ready handshake. A
//   decoupled output register lets the input keep filling the next word while
//   the current word waits to drain. A flush pulse emits a partially filled
//   word. Unfilled slots in that word are zero.
//
// Ports:
//   clk  - single clock, all logic on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - complex_vector_packer_if.slave, which carries:
//          in_data/in_valid/in_ready   input handshake
//          flush                       partial-word emit request
//          out_data/out_valid/out_ready/out_count   output handshake
//
// Configuration:
//   COMPLEX_PACKER_MSB_FIRST_EN - when defined, the first word of a group goes
//   into the most significant slot and later words go into lower slots. When
//   undefined (the default), the first word goes into the least significant
//   slot.
// ---------------------------------------------------------------------------
module complex_vector_packer #(
    parameter int element_width               = 64,
    parameter int no_of_row_by_vector_modules = 4,
    parameter int pack_factor                 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    complex_vector_packer_if.slave     bus
);
    localparam int IW    = element_width * no_of_row_by_vector_modules;
    localparam int OW    = pack_factor * IW;
    localparam int CW    = $clog2(pack_factor + 1);
    localparam int CNT_W = $clog2(pack_factor);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]    buf_q, buf_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]    out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic             flush_pending_q, flush_pending_d;

    logic             free;
    logic             at_last;
    logic             in_ready;
    logic             accept;
    logic             complete;
    logic             flush_req;
    logic [CNT_W-1:0] slot;
    logic [CNT_W-1:0] cnt_next;
    logic [OW-1:0]    merged;

    // Handshake decode and assembly of the next buffer contents.
    // 'merged' is the buffer with this cycle's accepted word already
    // written in. A load in the same cycle therefore includes that word.
    always_comb begin
        free      = !out_valid_q || bus.out_ready;
        at_last   = (cnt_q == CNT_W'(pack_factor - 1));
        in_ready  = !rst && !flush_pending_q && !(at_last && !free);
        accept    = bus.in_valid && in_ready;
        complete  = accept && at_last;
        flush_req = flush_pending_q || bus.flush;
`ifdef COMPLEX_PACKER_MSB_FIRST_EN
        slot      = CNT_W'(pack_factor - 1) - cnt_q;
`else
        slot      = cnt_q;
`endif
        cnt_next  = accept ? cnt_q + CNT_W'(1) : cnt_q;
        merged    = buf_q;
        if (accept) begin
            for (int s = 0; s < pack_factor; s++) begin
                if (slot == CNT_W'(s)) begin
                    merged[s*IW +: IW] = bus.in_data;
                end
            end
        end
    end

    // Next-state selection for the assembly buffer, output register and flush.
    // A completing word takes priority over a flush in the same cycle, and
    // that flush is consumed. A flush that finds the output register busy is
    // remembered. While it is pending, the input is held off so the partial
    // word stays unchanged until it can be emitted.
    always_comb begin
        cnt_d           = cnt_next;
        buf_d           = merged;
        out_data_d      = out_data_q;
        out_count_d     = out_count_q;
        out_valid_d     = out_valid_q;
        flush_pending_d = flush_pending_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d      = merged;
            out_count_d     = CW'(pack_factor);
            out_valid_d     = 1'b1;
            cnt_d           = '0;
            buf_d           = '0;
            flush_pending_d = 1'b0;
        end else if (flush_req && free) begin
            flush_pending_d = 1'b0;
            if (cnt_next != '0) begin
                out_data_d  = merged;
                out_count_d = CW'(cnt_next);
                out_valid_d = 1'b1;
                cnt_d       = '0;
                buf_d       = '0;
            end
        end else if (flush_req) begin
            flush_pending_d = 1'b1;
        end
    end

    // State registers. Reset discards the partial word and any held output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q           <= '0;
            buf_q           <= '0;
            out_data_q      <= '0;
            out_count_q     <= '0;
            out_valid_q     <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            buf_q           <= buf_d;
            out_data_q      <= out_data_d;
            out_count_q     <= out_count_d;
            out_valid_q     <= out_valid_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_complex_vector_packer.sv
// ---------------------------------------------------------------------------
// tb_complex_vector_packer
//
// Purpose:
//   Directed testbench for complex_vector_packer with element_width=64,
//   no_of_row_by_vector_modules=4 and pack_factor=2, so IW=256 and OW=512.
//   The expected packed words are built by hand from the four test words
//   A..D. Slot ordering follows COMPLEX_PACKER_MSB_FIRST_EN.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_complex_vector_packer;
    localparam int IW = 256;
    localparam int OW = 512;

    localparam logic [IW-1:0] A    = 256'h1;
    localparam logic [IW-1:0] B    = 256'h2;
    localparam logic [IW-1:0] C    = 256'h3;
    localparam logic [IW-1:0] D    = 256'h4;
    localparam logic [IW-1:0] ZERO = '0;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    complex_vector_packer_if #(
        .element_width(64),
        .no_of_row_by_vector_modules(4),
        .pack_factor(2)
    ) bus ();

    complex_vector_packer #(
        .element_width(64),
        .no_of_row_by_vector_modules(4),
        .pack_factor(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word built from two words in arrival order.
    function automatic logic [OW-1:0] packTwo(input logic [IW-1:0] first, input logic [IW-1:0] second);
`ifdef COMPLEX_PACKER_MSB_FIRST_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

    // Expected output word for a partial flush holding a single word.
    function automatic logic [OW-1:0] packOne(input logic [IW-1:0] first);
`ifdef COMPLEX_PACKER_MSB_FIRST_EN
        return {first, ZERO};
`else
        return {ZERO, first};
`endif
    endfunction

    // Counts a comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [OW-1:0] observed, input logic [OW-1:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs on the falling edge and then waits 1 time unit.
    // After that, outputs show the state from the last rising edge, and
    // in_ready reflects the new inputs.
    task automatic applyStimulus(input logic rstVal, input logic inValid, input logic [IW-1:0] inData,
                                 input logic flushVal, input logic outReady);
        @(negedge clk);
        rst           = rstVal;
        bus.in_valid  = inValid;
        bus.in_data   = inData;
        bus.flush     = flushVal;
        bus.out_ready = outReady;
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        applyStimulus(1, 0, ZERO, 0, 1);
        applyStimulus(1, 1, A, 0, 1);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_count", bus.out_count, 0);

        // Test 1: A then B
        applyStimulus(0, 1, A, 0, 1);
        checkOutput("t1_in_ready_first", bus.in_ready, 1);
        applyStimulus(0, 1, B, 0, 1);
        checkOutput("t1_in_ready_b", bus.in_ready, 1);
        checkOutput("t1_valid_before", bus.out_valid, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t1_valid", bus.out_valid, 1);
        checkOutput("t1_data", bus.out_data, packTwo(A, B));
        checkOutput("t1_count", bus.out_count, 2);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t1_valid_after", bus.out_valid, 0);

        // Test 2: back-to-back stream
        applyStimulus(0, 1, A, 0, 1);
        checkOutput("t2_ready_a", bus.in_ready, 1);
        applyStimulus(0, 1, B, 0, 1);
        checkOutput("t2_ready_b", bus.in_ready, 1);
        applyStimulus(0, 1, C, 0, 1);
        checkOutput("t2_ready_c", bus.in_ready, 1);
        checkOutput("t2_valid_ba", bus.out_valid, 1);
        checkOutput("t2_data_ba", bus.out_data, packTwo(A, B));
        applyStimulus(0, 1, D, 0, 1);
        checkOutput("t2_ready_d", bus.in_ready, 1);
        checkOutput("t2_valid_gap", bus.out_valid, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t2_valid_dc", bus.out_valid, 1);
        checkOutput("t2_data_dc", bus.out_data, packTwo(C, D));
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t2_valid_after", bus.out_valid, 0);

        // Test 3: output held, C accepted, D stalls until drain+reload
        applyStimulus(0, 1, A, 0, 0);
        applyStimulus(0, 1, B, 0, 0);
        applyStimulus(0, 1, C, 0, 0);
        checkOutput("t3_ready_c", bus.in_ready, 1);
        checkOutput("t3_held_valid", bus.out_valid, 1);
        checkOutput("t3_held_data", bus.out_data, packTwo(A, B));
        applyStimulus(0, 1, D, 0, 0);
        checkOutput("t3_stall_d0", bus.in_ready, 0);
        checkOutput("t3_held_data2", bus.out_data, packTwo(A, B));
        applyStimulus(0, 1, D, 0, 0);
        checkOutput("t3_stall_d1", bus.in_ready, 0);
        applyStimulus(0, 1, D, 0, 1);
        checkOutput("t3_ready_d", bus.in_ready, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t3_reload_valid", bus.out_valid, 1);
        checkOutput("t3_reload_data", bus.out_data, packTwo(C, D));
        checkOutput("t3_reload_count", bus.out_count, 2);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t3_valid_after", bus.out_valid, 0);

        // Test 4a: A then flush
        applyStimulus(0, 1, A, 0, 1);
        applyStimulus(0, 0, ZERO, 1, 1);
        checkOutput("t4a_valid_before", bus.out_valid, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4a_valid", bus.out_valid, 1);
        checkOutput("t4a_data", bus.out_data, packOne(A));
        checkOutput("t4a_count", bus.out_count, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4a_valid_after", bus.out_valid, 0);

        // Test 4b: flush with an empty buffer emits nothing
        applyStimulus(0, 0, ZERO, 1, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4b_no_output", bus.out_valid, 0);
        checkOutput("t4b_ready", bus.in_ready, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4b_no_output2", bus.out_valid, 0);

        // Test 4c: flush together with A while the output is held
        applyStimulus(0, 1, C, 0, 0);
        applyStimulus(0, 1, D, 0, 0);
        applyStimulus(0, 1, A, 1, 0);
        checkOutput("t4c_ready_a", bus.in_ready, 1);
        checkOutput("t4c_held_valid", bus.out_valid, 1);
        applyStimulus(0, 1, B, 0, 0);
        checkOutput("t4c_pending_ready0", bus.in_ready, 0);
        checkOutput("t4c_held_data", bus.out_data, packTwo(C, D));
        applyStimulus(0, 1, B, 0, 0);
        checkOutput("t4c_pending_ready1", bus.in_ready, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4c_pending_ready2", bus.in_ready, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4c_valid", bus.out_valid, 1);
        checkOutput("t4c_data", bus.out_data, packOne(A));
        checkOutput("t4c_count", bus.out_count, 1);
        checkOutput("t4c_ready_after", bus.in_ready, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t4c_valid_after", bus.out_valid, 0);

        // Flush coinciding with a completing word: the full word wins
        applyStimulus(0, 1, A, 0, 1);
        applyStimulus(0, 1, B, 1, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("coinc_data", bus.out_data, packTwo(A, B));
        checkOutput("coinc_count", bus.out_count, 2);
        checkOutput("coinc_ready", bus.in_ready, 1);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("coinc_no_extra", bus.out_valid, 0);

        // Test 5: reset mid-operation discards A
        applyStimulus(0, 1, A, 0, 1);
        applyStimulus(1, 1, C, 0, 1);
        checkOutput("t5_rst_ready", bus.in_ready, 0);
        applyStimulus(0, 1, B, 0, 1);
        checkOutput("t5_after_rst_data", bus.out_data, 0);
        checkOutput("t5_after_rst_valid", bus.out_valid, 0);
        checkOutput("t5_after_rst_count", bus.out_count, 0);
        checkOutput("t5_ready_b", bus.in_ready, 1);
        applyStimulus(0, 1, C, 0, 1);
        checkOutput("t5_no_a", bus.out_valid, 0);
        applyStimulus(0, 0, ZERO, 0, 1);
        checkOutput("t5_valid", bus.out_valid, 1);
        checkOutput("t5_data", bus.out_data, packTwo(B, C));
        checkOutput("t5_count", bus.out_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
